// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM encodings and
// helpers that classify opcodes for the iterative multiply/divide unit.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MD   = 1'b1;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_kind_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic md_kind_e md_kind(input logic [3:0] op);
    md_kind_e k;
    case (op)
      OP_DIVU: k = MD_DIVU;
      OP_REMU: k = MD_REMU;
      default: k = MD_MUL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/exec_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// done and result are combinational during the final iteration cycle.
module exec_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic            active_q, active_d;
  md_kind_e        kind_q, kind_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // opa: multiplicand (MUL) or dividend/quotient shift register (DIV)
  // opb: multiplier (MUL) or divisor (DIV); acc: product or partial remainder
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] acc_q, acc_d;

  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] step_acc, step_opa, step_opb;

  always_comb begin
    rem_sh   = {acc_q, opa_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opb_q};
    step_acc = acc_q;
    step_opa = opa_q;
    step_opb = opb_q;
    if (kind_q == MD_MUL) begin
      step_acc = opb_q[0] ? acc_q + opa_q : acc_q;
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end else begin
      // A zero divisor always passes the trial subtract: quotient all ones,
      // remainder equals the dividend.
      step_acc = rem_ge ? XLEN'(rem_sh - {1'b0, opb_q}) : rem_sh[XLEN-1:0];
      step_opa = {opa_q[XLEN-2:0], rem_ge};
    end
  end

  assign done   = active_q && (cnt_q == CNTW'(XLEN - 1));
  assign result = (kind_q == MD_DIVU) ? step_opa : step_acc;

  always_comb begin
    active_d = active_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    if (go && !active_q) begin
      active_d = 1'b1;
      kind_d   = md_kind(op);
      cnt_d    = '0;
      opa_d    = a;
      opb_d    = b;
      acc_d    = '0;
    end else if (active_q) begin
      opa_d = step_opa;
      opb_d = step_opb;
      acc_d = step_acc;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      kind_q   <= MD_MUL;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU, branch-target adder and a busy/done FSM
// that sequences the iterative multiply/divide unit.
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alu_op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc_in,
  input  logic [REGW-1:0] write_reg_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] branch_target,
  output logic [REGW-1:0] write_reg_out
);

  logic [0:0]      state_q, state_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] bt_q, bt_d;
  logic [REGW-1:0] wr_q, wr_d;

  logic [XLEN-1:0] op_b;
  logic [CNTW-1:0] shamt;
  logic [XLEN-1:0] alu_res;
  logic            md_go, md_done;
  logic [XLEN-1:0] md_result;

  assign op_b  = use_imm ? imm : src_b;
  assign shamt = op_b[CNTW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = src_a + op_b;
      OP_SUB:  alu_res = src_a - op_b;
      OP_AND:  alu_res = src_a & op_b;
      OP_OR:   alu_res = src_a | op_b;
      OP_XOR:  alu_res = src_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < op_b};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_LUI:  alu_res = op_b << 16;
      default: alu_res = '0;
    endcase
  end

  assign md_go = (state_q == ST_IDLE) && start && is_multicycle(alu_op);

  exec_muldiv #(
    .XLEN (XLEN),
    .CNTW (CNTW)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .go     (md_go),
    .op     (alu_op),
    .a      (src_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    bt_d     = bt_q;
    wr_d     = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bt_d = pc_in + (imm << 2);
          wr_d = write_reg_in;
          if (is_multicycle(alu_op)) begin
            state_d = ST_MD;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        // start is ignored here; the front end is stalled by busy
        if (md_done) begin
          result_d = md_result;
          zero_d   = (md_result == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      bt_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      bt_q     <= bt_d;
      wr_q     <= wr_d;
    end
  end

  assign busy          = (state_q == ST_MD);
  assign done          = done_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign branch_target = bt_q;
  assign write_reg_out = wr_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: expected completions are queued at issue
// and compared (value, flags, latency, busy length) when done pulses.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int MD_LAT = 33;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [3:0]      alu_op;
  logic            use_imm;
  logic [XLEN-1:0] src_a, src_b, imm, pc_in;
  logic [REGW-1:0] write_reg_in;
  logic            busy, done, zero;
  logic [XLEN-1:0] result, branch_target;
  logic [REGW-1:0] write_reg_out;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [31:0] bt;
    logic [4:0]  wr;
    int          due;
    int          busy_cycles;
  } exp_t;

  exp_t  sb[$];
  string names[$];
  exp_t  mon_e;
  string mon_name;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int busy_until = 0;
  int busy_run = 0;

  exec_unit #(.XLEN(XLEN), .REGW(REGW), .CNTW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .alu_op        (alu_op),
    .use_imm       (use_imm),
    .src_a         (src_a),
    .src_b         (src_b),
    .imm           (imm),
    .pc_in         (pc_in),
    .write_reg_in  (write_reg_in),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .zero          (zero),
    .branch_target (branch_target),
    .write_reg_out (write_reg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_LUI:  return b << 16;
      OP_MUL:  return 32'(64'(a) * 64'(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic ui,
                        input logic [31:0] pc, input logic [4:0] wr);
    exp_t e;
    logic [31:0] bb;
    @(negedge clk);
    start = 1'b1; alu_op = op; src_a = a; src_b = b; imm = im; use_imm = ui;
    pc_in = pc; write_reg_in = wr;
    if (cyc >= busy_until) begin
      bb = ui ? im : b;
      e.res = model(op, a, bb);
      e.z   = (e.res == 32'd0);
      e.bt  = pc + (im << 2);
      e.wr  = wr;
      if (is_multicycle(op)) begin
        e.due = cyc + MD_LAT;
        e.busy_cycles = MD_LAT - 1;
        busy_until = cyc + MD_LAT;
      end else begin
        e.due = cyc + 1;
        e.busy_cycles = 0;
      end
      sb.push_back(e);
      names.push_back(name);
    end else begin
      $display("issue %-16s while busy, expect ignored", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    @(negedge clk);
    start = 1'b0;
    check("sb_drained", sb.size(), 0);
    if (sb.size() != 0) begin
      sb.delete();
      names.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_name = names.pop_front();
          check({mon_name, "_result"}, result, mon_e.res);
          check({mon_name, "_zero"}, 32'(zero), 32'(mon_e.z));
          check({mon_name, "_btarget"}, branch_target, mon_e.bt);
          check({mon_name, "_wreg"}, 32'(write_reg_out), 32'(mon_e.wr));
          check({mon_name, "_latency"}, cyc, mon_e.due);
          check({mon_name, "_busycyc"}, busy_run, mon_e.busy_cycles);
          $display("txn %-16s result=%08h zero=%0d bt=%08h wr=%0d busy=%0d",
                   mon_name, result, zero, branch_target, write_reg_out, busy_run);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; alu_op = '0; use_imm = 1'b0;
    src_a = '0; src_b = '0; imm = '0; pc_in = '0; write_reg_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", result, 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_btarget", branch_target, 0);
    check("rst_wreg", 32'(write_reg_out), 0);
    reset = 1'b0;

    run_op("add_imm", OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 32'h100, 5'd1);
    drain();

    run_op("mul_abort", OP_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 32'h40, 5'd3);
    idle(9);
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", result, 0);
    check("abort_btarget", branch_target, 0);
    check("abort_wreg", 32'(write_reg_out), 0);
    sb.delete();
    names.delete();
    busy_until = 0;
    @(negedge clk);
    reset = 1'b0;
    run_op("add_after_abort", OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 32'h200, 5'd4);
    drain();

    run_op("sub_zero", OP_SUB, 32'h1234, 32'h1234, 32'd0, 1'b0, 32'h300, 5'd2);
    run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h304, 5'd5);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h308, 5'd6);
    run_op("undef_op", 4'd14, 32'd5, 32'd6, 32'd3, 1'b0, 32'h30C, 5'd8);
    drain();

    run_op("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 32'h1000, 5'd7);
    run_op("add_ignored", OP_ADD, 32'd1, 32'd2, 32'd1, 1'b0, 32'h2000, 5'd30);
    drain();

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd4, 1'b0, 32'h400, 5'd9);
    drain();
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'hFFFF_FFFF, 1'b0, 32'h404, 5'd9);
    drain();
    run_op("divu_by0", OP_DIVU, 32'd55, 32'd0, 32'd0, 1'b0, 32'h408, 5'd9);
    drain();
    run_op("remu_by0", OP_REMU, 32'd55, 32'd0, 32'd0, 1'b0, 32'h40C, 5'd9);
    drain();

    run_op("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0, 32'h500, 5'd10);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'h504, 5'd11);
    run_op("lui", OP_LUI, 32'd0, 32'd0, 32'h1234, 1'b1, 32'h508, 5'd12);
    drain();

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb, $urandom, 1'($urandom_range(0, 1)),
             $urandom, 5'($urandom_range(0, 31)));
      if (is_multicycle(rop)) drain();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
